cache_replace_policy: RTL and testbench
=======================================

// Module: cache_replace_policy
// PURPOSE
//  Stateful victim-selection unit for a set-associative cache. It holds per-set
//  replacement state for all sets and updates it on every cache access.
//  On request it returns the line to evict, with one cycle of latency.
//  Invalid lines always win. Otherwise the line is chosen by a selectable
//  policy: true LRU, FIFO or pseudo-random. Sits beside the tag array in the
//  cache controller and is queried on every miss.
// PARAMETERS
//  NUM_SETS   default 4          number of sets; power of 2, >=1
//  SET_SIZE   default `CACHE_E   lines per set (E); power of 2, >=2, else $error
//  POLICY     default 0          0=LRU, 1=FIFO, 2=RANDOM; any other value -> $error
//  K = $clog2(SET_SIZE), S = max(1,$clog2(NUM_SETS))   (derived, not overridable)
// PORTS
//  clk           in   1         clock, rising edge
//  resetn        in   1         asynchronous reset, active low
//  access_valid  in   1         a cache access (hit or fill) happens this cycle
//  access_set    in   S         set of the access
//  access_line   in   K         line touched within the set
//  access_fill   in   1         1 = line was just filled, 0 = hit
//  victim_req    in   1         single-cycle victim query; may be issued every cycle
//  victim_set    in   S         set being queried
//  valid_mask    in   SET_SIZE  valid bits of the queried set; bit i = line i
//  victim_valid  out  1         response strobe, 1 cycle after victim_req
//  victim_line   out  K         chosen line; meaningful while victim_valid=1
// BEHAVIOUR
//  - State
//    - LRU: rank[s][l], K bits each; 0=MRU, E-1=LRU. Ranks in a set always form a permutation.
//    - FIFO: ptr[s], K bits.
//    - RANDOM: 16-bit Fibonacci LFSR, taps 16,14,13,11; advances every cycle.
//  - Reset (resetn=0, async): rank[s][l]=l; ptr[s]=0; lfsr=16'hACE1;
//    victim_valid=0; victim_line=0. Reset mid-request drops the pending response.
//  - Victim selection (combinational on current state, registered into the outputs at clk edge)
//    - If valid_mask != all-ones: lowest-index line with valid_mask bit = 0.
//    - Else LRU: the line with rank == E-1.
//    - Else FIFO: ptr[victim_set].
//    - Else RANDOM: lfsr[K-1:0] (value before this edge's advance).
//  - Response timing
//    - Edge N with victim_req=1: victim_valid<=1 and victim_line<=selection.
//    - Edge N with victim_req=0: victim_valid<=0 and victim_line holds.
//  - Update on access_valid, at the edge
//    - LRU (hit or fill): let o = old rank[set][line]. Lines with rank < o
//      increment by 1; touched line <= 0; lines with rank > o unchanged.
//    - FIFO: a fill sets ptr[set] <= access_line+1 (mod E, natural K-bit wrap). Hits do not change ptr.
//    - RANDOM: no per-set state.
//    - Only access_set is modified; other sets hold.
//  - Simultaneous access and victim_req, same set: the victim is computed from
//    pre-update state (read-before-write). The update still commits at the same edge.
//  - Inputs are ignored when their valid bit is 0.
//  - access_set and victim_set ranges are inherent to the port widths, so no range check is needed.
//  - No combinational path from any input to any output.
// TESTING (NUM_SETS=4, SET_SIZE=4)
//  1. Reset, LRU, victim_req set2 mask 4'b1111 -> next cycle victim_valid=1, line 3; following cycle victim_valid=0.
//  2. LRU, victim_req set0 mask 4'b1011 -> line 2 (invalid beats LRU); mask 4'b0000 -> line 0.
//  3. LRU set0: hits on lines 3,1,0,2, then req mask 4'b1111 -> line 3. Hit line 3, then req -> line 1.
//  4. LRU, same cycle: hit set1 line3 + req set1 mask 4'b1111 -> line 3. Next req -> line 2. Set0 untouched -> line 3.
//  5. FIFO: fills set1 line0, line1 -> req -> line 2. Hit set1 line2 -> req still line 2. Fill line3 -> req -> line 0 (wrap).
//  6. RANDOM: 20 back-to-back reqs -> lines match the reference LFSR model from seed ACE1.
//     Assert resetn low mid-burst -> victim_valid=0 immediately; after release, LFSR restarts at ACE1.

Source files
------------

// File: rtl/cache_replace_policy.sv
// Victim selection for a set-associative cache: invalid line first, else LRU / FIFO / LFSR random.
// Latency: one cycle from victim_req to victim_valid. No backpressure: a query is accepted every cycle.
`ifndef CACHE_E
`define CACHE_E 4
`endif

module cache_replace_policy #(
  parameter int NUM_SETS = 4,
  parameter int SET_SIZE = `CACHE_E,
  parameter int POLICY   = 0,
  localparam int K = $clog2(SET_SIZE),
  localparam int S = (NUM_SETS > 1) ? $clog2(NUM_SETS) : 1
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                access_valid,
  input  logic [S-1:0]        access_set,
  input  logic [K-1:0]        access_line,
  input  logic                access_fill,
  input  logic                victim_req,
  input  logic [S-1:0]        victim_set,
  input  logic [SET_SIZE-1:0] valid_mask,
  output logic                victim_valid,
  output logic [K-1:0]        victim_line
);

  // State arrays cover every encodable set index so port-driven indexing never goes out of range.
  localparam int NS = 1 << S;

  if (SET_SIZE < 2 || (SET_SIZE & (SET_SIZE - 1)) != 0) begin : g_bad_set_size
    $error("cache_replace_policy: SET_SIZE must be a power of 2 and >= 2");
  end
  if (POLICY < 0 || POLICY > 2) begin : g_bad_policy
    $error("cache_replace_policy: POLICY must be 0 (LRU), 1 (FIFO) or 2 (RANDOM)");
  end

  logic [K-1:0] r_rank [NS][SET_SIZE];
  logic [K-1:0] r_ptr  [NS];
  logic [15:0]  r_lfsr;
  logic         r_victim_valid;
  logic [K-1:0] r_victim_line;

  logic [K-1:0] w_inv_line;
  logic [K-1:0] w_lru_line;
  logic [K-1:0] w_sel;
  logic         w_lfsr_fb;

  // Walk downwards so the lowest-index invalid line is the last one written.
  always_comb begin
    w_inv_line = '0;
    for (int l = SET_SIZE - 1; l >= 0; l--) begin
      if (!valid_mask[l]) w_inv_line = K'(l);
    end
  end

  always_comb begin
    w_lru_line = '0;
    for (int l = 0; l < SET_SIZE; l++) begin
      if (r_rank[victim_set][l] == K'(SET_SIZE - 1)) w_lru_line = K'(l);
    end
  end

  always_comb begin
    if (!(&valid_mask))   w_sel = w_inv_line;
    else if (POLICY == 0) w_sel = w_lru_line;
    else if (POLICY == 1) w_sel = r_ptr[victim_set];
    else                  w_sel = r_lfsr[K-1:0];
  end

  assign w_lfsr_fb = r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5];

  // Selection reads pre-update state, so a same-cycle access to the queried set is not yet visible.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_victim_valid <= 1'b0;
      r_victim_line  <= '0;
      r_lfsr         <= 16'hACE1;
    end else begin
      r_victim_valid <= victim_req;
      if (victim_req) r_victim_line <= w_sel;
      r_lfsr <= {w_lfsr_fb, r_lfsr[15:1]};
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int s = 0; s < NS; s++) begin
        for (int l = 0; l < SET_SIZE; l++) r_rank[s][l] <= K'(l);
      end
    end else if (access_valid) begin
      for (int l = 0; l < SET_SIZE; l++) begin
        if (K'(l) == access_line)
          r_rank[access_set][l] <= '0;
        else if (r_rank[access_set][l] < r_rank[access_set][access_line])
          r_rank[access_set][l] <= r_rank[access_set][l] + K'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int s = 0; s < NS; s++) r_ptr[s] <= '0;
    end else if (access_valid && access_fill) begin
      r_ptr[access_set] <= access_line + K'(1);
    end
  end

  assign victim_valid = r_victim_valid;
  assign victim_line  = r_victim_line;

endmodule

// File: tb/tb_cache_replace_policy.sv
// Directed bench: one instance per policy, shared stimulus, checks 1 ns after each rising edge.
// Expected values are hand-derived rank/pointer traces plus a reference LFSR seeded with ACE1.
module tb_cache_replace_policy;

  logic       clk = 1'b0;
  logic       resetn;
  logic       access_valid;
  logic [1:0] access_set;
  logic [1:0] access_line;
  logic       access_fill;
  logic       victim_req;
  logic [1:0] victim_set;
  logic [3:0] valid_mask;

  logic       v_lru, v_fifo, v_rnd;
  logic [1:0] l_lru, l_fifo, l_rnd;

  int checks = 0;
  int errors = 0;

  logic [1:0]  hit_seq [4] = '{2'd3, 2'd1, 2'd0, 2'd2};
  logic [15:0] model;

  always #5 clk = ~clk;

  cache_replace_policy #(.NUM_SETS(4), .SET_SIZE(4), .POLICY(0)) u_lru (
    .clk(clk), .resetn(resetn), .access_valid(access_valid), .access_set(access_set),
    .access_line(access_line), .access_fill(access_fill), .victim_req(victim_req),
    .victim_set(victim_set), .valid_mask(valid_mask),
    .victim_valid(v_lru), .victim_line(l_lru));

  cache_replace_policy #(.NUM_SETS(4), .SET_SIZE(4), .POLICY(1)) u_fifo (
    .clk(clk), .resetn(resetn), .access_valid(access_valid), .access_set(access_set),
    .access_line(access_line), .access_fill(access_fill), .victim_req(victim_req),
    .victim_set(victim_set), .valid_mask(valid_mask),
    .victim_valid(v_fifo), .victim_line(l_fifo));

  cache_replace_policy #(.NUM_SETS(4), .SET_SIZE(4), .POLICY(2)) u_rnd (
    .clk(clk), .resetn(resetn), .access_valid(access_valid), .access_set(access_set),
    .access_line(access_line), .access_fill(access_fill), .victim_req(victim_req),
    .victim_set(victim_set), .valid_mask(valid_mask),
    .victim_valid(v_rnd), .victim_line(l_rnd));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    access_valid = 1'b0;
    access_fill  = 1'b0;
    access_set   = 2'd0;
    access_line  = 2'd0;
    victim_req   = 1'b0;
    victim_set   = 2'd0;
    valid_mask   = 4'hF;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    idle();
    repeat (2) tick();
    @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    idle();
    victim_req = 1'b1;
    repeat (2) tick();
    checks++; if (v_lru !== 1'b0)  begin errors++; $display("FAIL reset_v_lru: got %b expected 0", v_lru); end
    checks++; if (v_fifo !== 1'b0) begin errors++; $display("FAIL reset_v_fifo: got %b expected 0", v_fifo); end
    checks++; if (v_rnd !== 1'b0)  begin errors++; $display("FAIL reset_v_rnd: got %b expected 0", v_rnd); end
    checks++; if (l_lru !== 2'd0)  begin errors++; $display("FAIL reset_l_lru: got %0d expected 0", l_lru); end
    checks++; if (l_fifo !== 2'd0) begin errors++; $display("FAIL reset_l_fifo: got %0d expected 0", l_fifo); end
    checks++; if (l_rnd !== 2'd0)  begin errors++; $display("FAIL reset_l_rnd: got %0d expected 0", l_rnd); end
    victim_req = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic test_lru_reset_victim();
    do_reset();
    victim_req = 1'b1; victim_set = 2'd2; valid_mask = 4'hF;
    tick();
    victim_req = 1'b0;
    checks++; if (v_lru !== 1'b1) begin errors++; $display("FAIL t1_valid: got %b expected 1", v_lru); end
    checks++; if (l_lru !== 2'd3) begin errors++; $display("FAIL t1_line: got %0d expected 3", l_lru); end
    tick();
    checks++; if (v_lru !== 1'b0) begin errors++; $display("FAIL t1_valid_drop: got %b expected 0", v_lru); end
    checks++; if (l_lru !== 2'd3) begin errors++; $display("FAIL t1_line_hold: got %0d expected 3", l_lru); end
  endtask

  task automatic test_invalid_first();
    do_reset();
    victim_req = 1'b1; victim_set = 2'd0; valid_mask = 4'b1011;
    tick();
    checks++; if (l_lru !== 2'd2)  begin errors++; $display("FAIL t2_lru_1011: got %0d expected 2", l_lru); end
    checks++; if (l_fifo !== 2'd2) begin errors++; $display("FAIL t2_fifo_1011: got %0d expected 2", l_fifo); end
    valid_mask = 4'b0000;
    tick();
    victim_req = 1'b0;
    checks++; if (v_lru !== 1'b1) begin errors++; $display("FAIL t2_b2b_valid: got %b expected 1", v_lru); end
    checks++; if (l_lru !== 2'd0) begin errors++; $display("FAIL t2_lru_0000: got %0d expected 0", l_lru); end
    valid_mask = 4'b0111;
    victim_req = 1'b1;
    tick();
    victim_req = 1'b0;
    checks++; if (l_rnd !== 2'd3) begin errors++; $display("FAIL t2_rnd_0111: got %0d expected 3", l_rnd); end
  endtask

  task automatic test_lru_order();
    do_reset();
    access_valid = 1'b1; access_set = 2'd0; access_fill = 1'b0;
    for (int i = 0; i < 4; i++) begin
      access_line = hit_seq[i];
      tick();
    end
    access_valid = 1'b0;
    victim_req = 1'b1; victim_set = 2'd0; valid_mask = 4'hF;
    tick();
    victim_req = 1'b0;
    checks++; if (l_lru !== 2'd3) begin errors++; $display("FAIL t3_after_seq: got %0d expected 3", l_lru); end
    access_valid = 1'b1; access_line = 2'd3;
    tick();
    access_valid = 1'b0;
    victim_req = 1'b1;
    tick();
    victim_req = 1'b0;
    checks++; if (l_lru !== 2'd1) begin errors++; $display("FAIL t3_after_hit3: got %0d expected 1", l_lru); end
  endtask

  task automatic test_same_cycle();
    do_reset();
    access_valid = 1'b1; access_set = 2'd1; access_line = 2'd3; access_fill = 1'b0;
    victim_req = 1'b1; victim_set = 2'd1; valid_mask = 4'hF;
    tick();
    access_valid = 1'b0;
    checks++; if (l_lru !== 2'd3) begin errors++; $display("FAIL t4_pre_update: got %0d expected 3", l_lru); end
    tick();
    checks++; if (l_lru !== 2'd2) begin errors++; $display("FAIL t4_post_update: got %0d expected 2", l_lru); end
    victim_set = 2'd0;
    tick();
    victim_req = 1'b0;
    checks++; if (l_lru !== 2'd3) begin errors++; $display("FAIL t4_other_set: got %0d expected 3", l_lru); end
    checks++; if (v_lru !== 1'b1) begin errors++; $display("FAIL t4_valid: got %b expected 1", v_lru); end
  endtask

  task automatic test_fifo();
    do_reset();
    access_valid = 1'b1; access_set = 2'd1; access_fill = 1'b1; access_line = 2'd0;
    tick();
    access_line = 2'd1;
    tick();
    access_valid = 1'b0;
    victim_req = 1'b1; victim_set = 2'd1; valid_mask = 4'hF;
    tick();
    victim_req = 1'b0;
    checks++; if (l_fifo !== 2'd2) begin errors++; $display("FAIL t5_after_fills: got %0d expected 2", l_fifo); end
    access_valid = 1'b1; access_fill = 1'b0; access_line = 2'd2;
    tick();
    access_valid = 1'b0;
    victim_req = 1'b1;
    tick();
    victim_req = 1'b0;
    checks++; if (l_fifo !== 2'd2) begin errors++; $display("FAIL t5_hit_no_move: got %0d expected 2", l_fifo); end
    access_valid = 1'b1; access_fill = 1'b1; access_line = 2'd3;
    tick();
    access_valid = 1'b0;
    victim_req = 1'b1;
    tick();
    victim_req = 1'b0;
    checks++; if (l_fifo !== 2'd0) begin errors++; $display("FAIL t5_wrap: got %0d expected 0", l_fifo); end
    access_valid = 1'b1; access_fill = 1'b1; access_line = 2'd0;
    victim_req = 1'b1;
    tick();
    access_valid = 1'b0;
    checks++; if (l_fifo !== 2'd0) begin errors++; $display("FAIL t5_same_cycle: got %0d expected 0", l_fifo); end
    tick();
    victim_req = 1'b0;
    checks++; if (l_fifo !== 2'd1) begin errors++; $display("FAIL t5_after_fill0: got %0d expected 1", l_fifo); end
    victim_req = 1'b1; victim_set = 2'd2; access_valid = 1'b1; access_set = 2'd2; access_line = 2'd2;
    tick();
    access_valid = 1'b0;
    checks++; if (l_fifo !== 2'd0) begin errors++; $display("FAIL t5_set2_initial: got %0d expected 0", l_fifo); end
    victim_set = 2'd1;
    tick();
    victim_req = 1'b0;
    checks++; if (l_fifo !== 2'd1) begin errors++; $display("FAIL t5_set1_isolated: got %0d expected 1", l_fifo); end
  endtask

  task automatic test_random_back_to_back();
    resetn = 1'b0;
    idle();
    victim_req = 1'b1;
    repeat (2) tick();
    @(negedge clk);
    resetn = 1'b1;
    model = 16'hACE1;
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++; if (v_rnd !== 1'b1) begin errors++; $display("FAIL t6_valid[%0d]: got %b expected 1", i, v_rnd); end
      checks++; if (l_rnd !== model[1:0]) begin errors++; $display("FAIL t6_line[%0d]: got %0d expected %0d", i, l_rnd, model[1:0]); end
      model = {model[0] ^ model[2] ^ model[3] ^ model[5], model[15:1]};
    end
    resetn = 1'b0;
    #1;
    checks++; if (v_rnd !== 1'b0) begin errors++; $display("FAIL t6_async_valid: got %b expected 0", v_rnd); end
    checks++; if (l_rnd !== 2'd0) begin errors++; $display("FAIL t6_async_line: got %0d expected 0", l_rnd); end
    @(negedge clk);
    resetn = 1'b1;
    model = 16'hACE1;
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++; if (l_rnd !== model[1:0]) begin errors++; $display("FAIL t6_restart[%0d]: got %0d expected %0d", i, l_rnd, model[1:0]); end
      model = {model[0] ^ model[2] ^ model[3] ^ model[5], model[15:1]};
    end
    victim_req = 1'b0;
    tick();
    checks++; if (v_rnd !== 1'b0) begin errors++; $display("FAIL t6_end_valid: got %b expected 0", v_rnd); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_lru_reset_victim();
    test_invalid_first();
    test_lru_order();
    test_same_cycle();
    test_fifo();
    test_random_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
